display_monitor: RTL
====================

DISPLAY_MONITOR -- requirements
Module: display_monitor

Interface
REQ-001 SHALL have parameter SYNC_ACTIVE_LOW, default 1, meaning hsync/vsync are asserted low (0 = asserted high).
REQ-002 SHALL have parameter MIN_STROBE_GAP, default 4, the minimum number of clk cycles between disp_clk rising edges.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All logic runs in this domain.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have ports disp_clk, disp_en, disp_hsync, disp_vsync, inputs, 1 bit each: the panel interface being monitored, asynchronous to clk.
REQ-006 SHALL have ports disp_red, disp_green, disp_blue, inputs, 8 bits each: pixel data.
REQ-007 SHALL have ports probe_x and probe_y, inputs, 10 bits each: the pixel coordinate to capture.
REQ-008 SHALL have port line_pixels, output, 11 bits: the enabled-pixel count of the last complete line.
REQ-009 SHALL have port frame_lines, output, 10 bits: the active-line count of the last complete frame.
REQ-010 SHALL have port frame_count, output, 8 bits: completed frames, wrapping.
REQ-011 SHALL have port probe_rgb, output, 24 bits, ordered {R,G,B}; and port probe_valid, output, 1 bit.
REQ-012 SHALL have port timing_error, output, 1 bit, sticky.

Function
REQ-013 SHALL pass every disp_* input through a 2-flop synchronizer and then one edge register; pixel strobe = synchronized disp_clk rising edge.
REQ-014 All sampled fields SHALL be delayed by the same pipeline so that data is aligned with the strobe; strobe latency is 3 clk cycles after the disp_clk edge.
REQ-015 SHALL have FSM states SEARCH and IN_FRAME; reset enters SEARCH.
REQ-016 SEARCH SHALL move to IN_FRAME on a vsync assertion edge and clear x_cnt and y_cnt; strobes are ignored while in SEARCH.
REQ-017 In IN_FRAME, a strobe with en=1 SHALL increment x_cnt; x_cnt saturates at 2047.
REQ-018 An hsync assertion edge SHALL behave as follows when x_cnt>0: latch line_pixels=x_cnt, increment y_cnt (saturating at 1023), then clear x_cnt.
REQ-019 An hsync assertion edge with x_cnt=0 SHALL only clear x_cnt (blank line); y_cnt is unchanged.
REQ-020 A vsync assertion edge in IN_FRAME SHALL latch frame_lines=y_cnt, increment frame_count (255 wraps to 0), clear both counters and the reference line length, and stay in IN_FRAME.
REQ-021 The first non-blank line of each frame SHALL set the reference line length; any later line in the same frame with a different length SHALL set timing_error.
REQ-022 timing_error SHALL also be set when two strobes arrive closer than MIN_STROBE_GAP clk cycles apart.
REQ-023 When a strobe with en=1 has x_cnt==probe_x and y_cnt==probe_y (evaluated before the increment), the block SHALL latch probe_rgb and set probe_valid.
REQ-024 probe_valid SHALL clear at the next vsync edge and re-assert when the pixel is captured again.
REQ-025 Simultaneous hsync and vsync edges on the same cycle SHALL apply the hsync action first, then the vsync action.
REQ-026 A strobe on the same cycle as a sync edge SHALL be counted before the sync action.

Reset
REQ-027 On reset the block SHALL enter SEARCH and clear all counters, the reference line length, every output, and all synchronizer flops; reset mid-frame discards partial counts.

Configuration
REQ-028 With MONITOR_CHECKSUM_EN defined, the block SHALL add output frame_sum (16 bits): the running sum mod 2^16 of R+G+B over en=1 strobes in IN_FRAME, latched at each vsync edge with the accumulator then cleared.
REQ-029 With MONITOR_CHECKSUM_EN defined, frame_sum SHALL reset to 0.
REQ-030 Without MONITOR_CHECKSUM_EN, neither the port nor the accumulator SHALL exist.

Structure
REQ-031 Package display_mon_pkg SHALL hold the FSM state enum, the counter width constants (11/10/8) and the RGB width (24).
REQ-032 The block SHALL contain one sub-module, pixel_strobe_gen: the synchronizers, the edge register, strobe and sync-edge pulses, and the aligned data outputs.

Verification
REQ-033 Reset, then 3 frames of 640 px x 480 lines at a disp_clk period of 8 clk cycles -> line_pixels=640, frame_lines=480, frame_count=3, timing_error=0.
REQ-034 probe=(10,5) with a pixel value of 0x12AB34 only at that coordinate -> probe_rgb=0x12AB34 and probe_valid=1 before the next vsync; probe_valid=0 one cycle after that vsync edge.
REQ-035 One line of 639 px inside a 640-px frame -> timing_error=1 and held through later clean frames until reset.
REQ-036 Strobes 2 clk cycles apart -> timing_error=1; 256 clean frames -> frame_count wraps to 0.
REQ-037 Reset asserted mid-line after 100 px -> all outputs 0, FSM in SEARCH, and no count until the next vsync edge.
REQ-038 With MONITOR_CHECKSUM_EN defined, a 2x2 frame of 0xFFFFFF pixels -> frame_sum=0x0BF4; hsync and vsync edges on the same cycle -> the last line is counted in frame_lines.

Source files
------------

// File: rtl/display_mon_pkg.sv
// -----------------------------------------------------------------------------
// display_mon_pkg
// Shared definitions for the display_monitor block:
//   - mon_state_e : monitor FSM states (SEARCH, IN_FRAME)
//   - X_W / Y_W / FC_W : pixel, line and frame counter widths (11/10/8)
//   - RGB_W : packed {R,G,B} pixel width (24)
//   - SUM_W : frame checksum width (16, optional checksum feature only)
//   - rgb_add() : R+G+B of one packed pixel
// -----------------------------------------------------------------------------
package display_mon_pkg;

  typedef enum logic {
    SEARCH   = 1'b0,
    IN_FRAME = 1'b1
  } mon_state_e;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int FC_W  = 8;
  localparam int RGB_W = 24;
  localparam int SUM_W = 16;

  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;

  // Sum of the three 8-bit colour channels; 10 bits holds the maximum 765.
  function automatic logic [9:0] rgb_add(input logic [RGB_W-1:0] rgb);
    return {2'b00, rgb[23:16]} + {2'b00, rgb[15:8]} + {2'b00, rgb[7:0]};
  endfunction

endpackage

// File: rtl/display_monitor_pixel_strobe_gen.sv
// -----------------------------------------------------------------------------
// pixel_strobe_gen
// Brings the asynchronous panel interface into the clk domain. Every disp_*
// bit goes through the same two synchronizer flops, so pixel data, enable and
// syncs stay aligned with each other. An edge register holding the previous
// synchronized clock/sync levels turns them into one-cycle pulses.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   i_disp_clk           : panel pixel clock (async)
//   i_disp_en            : panel data enable (async)
//   i_disp_hsync/vsync   : panel syncs (async), polarity set by SYNC_ACTIVE_LOW
//   i_red/green/blue     : panel pixel data (async)
//   o_strobe             : one-cycle pulse per synchronized disp_clk rise
//   o_en, o_rgb          : enable and {R,G,B} aligned with o_strobe
//   o_hsync_edge         : one-cycle pulse on hsync assertion
//   o_vsync_edge         : one-cycle pulse on vsync assertion
// -----------------------------------------------------------------------------
module pixel_strobe_gen
  import display_mon_pkg::*;
#(
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_disp_clk,
  input  logic             i_disp_en,
  input  logic             i_disp_hsync,
  input  logic             i_disp_vsync,
  input  logic [7:0]       i_red,
  input  logic [7:0]       i_green,
  input  logic [7:0]       i_blue,
  output logic             o_strobe,
  output logic             o_en,
  output logic [RGB_W-1:0] o_rgb,
  output logic             o_hsync_edge,
  output logic             o_vsync_edge
);

  localparam int SW   = RGB_W + 4;
  localparam int B_CK = SW - 1;
  localparam int B_EN = SW - 2;
  localparam int B_HS = SW - 3;
  localparam int B_VS = SW - 4;
  localparam logic INV = (SYNC_ACTIVE_LOW != 0);

  logic [SW-1:0] w_raw;
  logic [SW-1:0] r_sync1;
  logic [SW-1:0] r_sync2;
  // Previous synchronized raw levels of {disp_clk, hsync, vsync}. Raw levels
  // (not asserted levels) are kept so that the all-zero reset state of both
  // stages compares equal and cannot fake a sync edge after reset.
  logic [2:0]    r_edge;

  logic w_hs_act;
  logic w_vs_act;
  logic w_hs_prev_act;
  logic w_vs_prev_act;

  assign w_raw = {i_disp_clk, i_disp_en, i_disp_hsync, i_disp_vsync,
                  i_red, i_green, i_blue};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_edge  <= {r_sync2[B_CK], r_sync2[B_HS], r_sync2[B_VS]};
    end
  end

  assign w_hs_act      = r_sync2[B_HS] ^ INV;
  assign w_vs_act      = r_sync2[B_VS] ^ INV;
  assign w_hs_prev_act = r_edge[1] ^ INV;
  assign w_vs_prev_act = r_edge[0] ^ INV;

  assign o_strobe     = r_sync2[B_CK] & ~r_edge[2];
  assign o_en         = r_sync2[B_EN];
  assign o_rgb        = r_sync2[RGB_W-1:0];
  assign o_hsync_edge = w_hs_act & ~w_hs_prev_act;
  assign o_vsync_edge = w_vs_act & ~w_vs_prev_act;

endmodule

// File: rtl/display_monitor.sv
// -----------------------------------------------------------------------------
// display_monitor
// Passive monitor for a parallel RGB panel interface. Measures enabled pixels
// per line, active lines per frame and completed frames, captures one probe
// pixel, and flags inconsistent line lengths or over-fast pixel strobes.
//
// Optional feature macro: MONITOR_CHECKSUM_EN adds the frame_sum output
// (mod-2^16 sum of R+G+B over the enabled pixels of each frame).
//
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   disp_clk/en/hsync/vsync   : monitored panel control (async to clk)
//   disp_red/green/blue       : monitored pixel data (async to clk)
//   probe_x, probe_y          : coordinate of the pixel to capture
//   line_pixels               : enabled-pixel count of the last complete line
//   frame_lines               : active-line count of the last complete frame
//   frame_count               : completed frames, wrapping
//   probe_rgb, probe_valid    : captured {R,G,B} and its valid flag
//   timing_error              : sticky line-length / strobe-gap violation
//   frame_sum                 : frame checksum (MONITOR_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module display_monitor
  import display_mon_pkg::*;
#(
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int MIN_STROBE_GAP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_clk,
  input  logic              disp_en,
  input  logic              disp_hsync,
  input  logic              disp_vsync,
  input  logic [7:0]        disp_red,
  input  logic [7:0]        disp_green,
  input  logic [7:0]        disp_blue,
  input  logic [9:0]        probe_x,
  input  logic [9:0]        probe_y,
  output logic [X_W-1:0]    line_pixels,
  output logic [Y_W-1:0]    frame_lines,
  output logic [FC_W-1:0]   frame_count,
  output logic [RGB_W-1:0]  probe_rgb,
  output logic              probe_valid,
  output logic              timing_error
`ifdef MONITOR_CHECKSUM_EN
  ,
  output logic [SUM_W-1:0]  frame_sum
`endif
);

  localparam int GAP_W = (MIN_STROBE_GAP < 1) ? 1 : $clog2(MIN_STROBE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(MIN_STROBE_GAP);

  logic             w_strobe;
  logic             w_en;
  logic [RGB_W-1:0] w_rgb;
  logic             w_hs_edge;
  logic             w_vs_edge;

  pixel_strobe_gen #(
    .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_strobe (
    .clk          (clk),
    .reset        (reset),
    .i_disp_clk   (disp_clk),
    .i_disp_en    (disp_en),
    .i_disp_hsync (disp_hsync),
    .i_disp_vsync (disp_vsync),
    .i_red        (disp_red),
    .i_green      (disp_green),
    .i_blue       (disp_blue),
    .o_strobe     (w_strobe),
    .o_en         (w_en),
    .o_rgb        (w_rgb),
    .o_hsync_edge (w_hs_edge),
    .o_vsync_edge (w_vs_edge)
  );

  mon_state_e       r_state;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [X_W-1:0]   r_ref;          // 0 = no reference line yet this frame
  logic [X_W-1:0]   r_line_pixels;
  logic [Y_W-1:0]   r_frame_lines;
  logic [FC_W-1:0]  r_frame_count;
  logic [RGB_W-1:0] r_probe_rgb;
  logic             r_probe_valid;
  logic             r_timing_error;
  logic [GAP_W-1:0] r_gap;          // clk cycles since last strobe, saturating
  logic             r_gap_armed;    // a previous strobe exists to measure from

  logic [X_W-1:0]   w_x_next;
  logic [Y_W-1:0]   w_y_next;
  logic [X_W-1:0]   w_ref_next;
  logic [X_W-1:0]   w_line_pixels_next;
  logic [Y_W-1:0]   w_frame_lines_next;
  logic [FC_W-1:0]  w_frame_count_next;
  logic [RGB_W-1:0] w_probe_rgb_next;
  logic             w_probe_valid_next;
  logic             w_line_err;
  logic             w_gap_err;

`ifdef MONITOR_CHECKSUM_EN
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_frame_sum;
  logic [SUM_W-1:0] w_acc_next;
  logic [SUM_W-1:0] w_frame_sum_next;
`endif

  assign w_gap_err = w_strobe & r_gap_armed & (r_gap < GAP_SAT);

  // Per-cycle frame bookkeeping. The ordering inside the IN_FRAME branch is
  // the event priority: a coincident strobe is counted first, then the hsync
  // action, then the vsync action sees the already-updated line count.
  always_comb begin
    w_x_next           = r_x;
    w_y_next           = r_y;
    w_ref_next         = r_ref;
    w_line_pixels_next = r_line_pixels;
    w_frame_lines_next = r_frame_lines;
    w_frame_count_next = r_frame_count;
    w_probe_rgb_next   = r_probe_rgb;
    w_probe_valid_next = r_probe_valid;
    w_line_err         = 1'b0;
`ifdef MONITOR_CHECKSUM_EN
    w_acc_next         = r_acc;
    w_frame_sum_next   = r_frame_sum;
`endif
    if (r_state == IN_FRAME) begin
      if (w_strobe && w_en) begin
        if ((r_x == {1'b0, probe_x}) && (r_y == probe_y)) begin
          w_probe_rgb_next   = w_rgb;
          w_probe_valid_next = 1'b1;
        end
        if (r_x != X_MAX) begin
          w_x_next = r_x + 1'b1;
        end
`ifdef MONITOR_CHECKSUM_EN
        w_acc_next = r_acc + {6'd0, rgb_add(w_rgb)};
`endif
      end
      if (w_hs_edge) begin
        // A line with no enabled pixels is blanking: not counted, not compared.
        if (w_x_next != '0) begin
          w_line_pixels_next = w_x_next;
          if (r_ref == '0) begin
            w_ref_next = w_x_next;
          end else if (r_ref != w_x_next) begin
            w_line_err = 1'b1;
          end
          if (r_y != Y_MAX) begin
            w_y_next = r_y + 1'b1;
          end
        end
        w_x_next = '0;
      end
      if (w_vs_edge) begin
        w_frame_lines_next = w_y_next;
        w_frame_count_next = r_frame_count + 1'b1;
        w_x_next           = '0;
        w_y_next           = '0;
        w_ref_next         = '0;
        w_probe_valid_next = 1'b0;
`ifdef MONITOR_CHECKSUM_EN
        w_frame_sum_next   = w_acc_next;
        w_acc_next         = '0;
`endif
      end
    end else if (w_vs_edge) begin
      w_x_next = '0;
      w_y_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= SEARCH;
      r_x            <= '0;
      r_y            <= '0;
      r_ref          <= '0;
      r_line_pixels  <= '0;
      r_frame_lines  <= '0;
      r_frame_count  <= '0;
      r_probe_rgb    <= '0;
      r_probe_valid  <= 1'b0;
      r_timing_error <= 1'b0;
      r_gap          <= '0;
      r_gap_armed    <= 1'b0;
`ifdef MONITOR_CHECKSUM_EN
      r_acc          <= '0;
      r_frame_sum    <= '0;
`endif
    end else begin
      case (r_state)
        SEARCH:   if (w_vs_edge) r_state <= IN_FRAME;
        IN_FRAME: r_state <= IN_FRAME;
        default:  r_state <= SEARCH;
      endcase
      r_x            <= w_x_next;
      r_y            <= w_y_next;
      r_ref          <= w_ref_next;
      r_line_pixels  <= w_line_pixels_next;
      r_frame_lines  <= w_frame_lines_next;
      r_frame_count  <= w_frame_count_next;
      r_probe_rgb    <= w_probe_rgb_next;
      r_probe_valid  <= w_probe_valid_next;
      r_timing_error <= r_timing_error | w_line_err | w_gap_err;
      if (w_strobe) begin
        r_gap       <= GAP_W'(1);
        r_gap_armed <= 1'b1;
      end else if (r_gap != GAP_SAT) begin
        r_gap <= r_gap + 1'b1;
      end
`ifdef MONITOR_CHECKSUM_EN
      r_acc          <= w_acc_next;
      r_frame_sum    <= w_frame_sum_next;
`endif
    end
  end

  assign line_pixels  = r_line_pixels;
  assign frame_lines  = r_frame_lines;
  assign frame_count  = r_frame_count;
  assign probe_rgb    = r_probe_rgb;
  assign probe_valid  = r_probe_valid;
  assign timing_error = r_timing_error;
`ifdef MONITOR_CHECKSUM_EN
  assign frame_sum    = r_frame_sum;
`endif

endmodule
